// File: rtl/spi_sfr_sequencer.sv
// spi_sfr_sequencer: runs one SPI byte transfer per request through the peripheral's SFR port
// Ports: clk/rst_n (async active-low); cfg_cr1/cfg_cr2/cfg_br + cfg_update pulse mark config dirty;
// req_valid/req_ready/req_data/req_slave request handshake; rsp_valid/rsp_ready/rsp_data/rsp_err response;
// busy when not idle; sfraddr_w/sfrwe/spidata_o write side; sfraddr_r/sfr_data_i read side (one-cycle latency).
// Optional SPI_SEQ_TIMEOUT_EN: aborts the done-bit wait after TIMEOUT_CYCLES with rsp_err=1.
module spi_sfr_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int HOLDOFF_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cfg_cr1,
  input  logic [7:0] cfg_cr2,
  input  logic [7:0] cfg_br,
  input  logic       cfg_update,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_data,
  input  logic       req_slave,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       busy,
  output logic [1:0] sfraddr_w,
  output logic       sfrwe,
  output logic [7:0] spidata_o,
  output logic [2:0] sfraddr_r,
  input  logic [7:0] sfr_data_i
);
  typedef enum logic [3:0] {IDLE, WR_CR1, WR_CR2, WR_BR, WR_DR, HOLD, WAIT_CLR, WAIT_SET, RD1, RD2, RESP} state_t;
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  state_t state;
  logic cfg_dirty, slave_q, done, to_hit;
  logic [7:0] data_q;
  logic [HW-1:0] hcnt;
  assign done = slave_q ? sfr_data_i[1] : sfr_data_i[0];
`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  assign to_hit = tcnt == TW'(TIMEOUT_CYCLES - 1);
`else
  logic unused_timeout;
  assign to_hit = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cfg_dirty <= 1'b1;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
      busy <= 1'b0;
      sfrwe <= 1'b0;
      sfraddr_w <= '0;
      spidata_o <= '0;
      sfraddr_r <= 3'd3;
      data_q <= '0;
      slave_q <= 1'b0;
      hcnt <= '0;
`ifdef SPI_SEQ_TIMEOUT_EN
      tcnt <= '0;
`endif
    end else begin
      // an update landing in the WR_BR cycle must survive the clear
      cfg_dirty <= cfg_update | (cfg_dirty & (state != WR_BR));
      sfrwe <= 1'b0;
      sfraddr_r <= 3'd3;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      busy <= 1'b1;
      case (state)
        IDLE:
          if (req_valid && req_ready) begin
            data_q <= req_data;
            slave_q <= req_slave;
            sfrwe <= 1'b1;
            state <= cfg_dirty ? WR_CR1 : WR_DR;
            sfraddr_w <= cfg_dirty ? 2'd0 : 2'd3;
            spidata_o <= cfg_dirty ? cfg_cr1 : req_data;
          end else begin
            busy <= 1'b0;
            req_ready <= 1'b1;
          end
        WR_CR1: begin
          state <= WR_CR2;
          sfrwe <= 1'b1;
          sfraddr_w <= 2'd1;
          spidata_o <= cfg_cr2;
        end
        WR_CR2: begin
          state <= WR_BR;
          sfrwe <= 1'b1;
          sfraddr_w <= 2'd2;
          spidata_o <= cfg_br;
        end
        WR_BR: begin
          state <= WR_DR;
          sfrwe <= 1'b1;
          sfraddr_w <= 2'd3;
          spidata_o <= data_q;
        end
        WR_DR: begin
          state <= HOLD;
          hcnt <= '0;
        end
        HOLD: begin
          hcnt <= hcnt + 1'b1;
          if (hcnt == HW'(HOLDOFF_CYCLES - 1)) state <= WAIT_CLR;
`ifdef SPI_SEQ_TIMEOUT_EN
          tcnt <= '0;
`endif
        end
        // WAIT_CLR drains a done level left over from the previous transfer
        WAIT_CLR, WAIT_SET: begin
`ifdef SPI_SEQ_TIMEOUT_EN
          tcnt <= tcnt + 1'b1;
`endif
          if (to_hit) begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_err <= 1'b1;
            rsp_data <= '0;
          end else if (state == WAIT_CLR && !done) state <= WAIT_SET;
          else if (state == WAIT_SET && done) begin
            state <= RD1;
            sfraddr_r <= 3'd5;
          end
        end
        RD1: begin
          state <= RD2;
          sfraddr_r <= 3'd5;
        end
        RD2: begin
          state <= RESP;
          rsp_valid <= 1'b1;
          rsp_data <= sfr_data_i;
          rsp_err <= 1'b0;
        end
        RESP:
          if (rsp_ready) begin
            state <= IDLE;
            busy <= 1'b0;
            req_ready <= 1'b1;
          end else rsp_valid <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_sfr_sequencer.sv
// tb_spi_sfr_sequencer: directed and randomized checks of spi_sfr_sequencer against a transaction-level model
module tb_spi_sfr_sequencer;
  localparam int TO = 64, HO = 2;
  logic clk = 0, rst_n = 0;
  logic [7:0] cfg_cr1 = 0, cfg_cr2 = 0, cfg_br = 0, req_data = 0, rsp_data, spidata_o;
  logic cfg_update = 0, req_valid = 0, req_ready, req_slave = 0, rsp_valid, rsp_ready = 0, rsp_err, busy, sfrwe;
  logic [1:0] sfraddr_w;
  logic [2:0] sfraddr_r;
  logic [7:0] status = 0, dr2 = 0, sfr_data = 0, edr;
  int ncomp = 0, nfail = 0, cyc = 0, n;
  bit mdirty = 1, ecfg;
  logic [15:0] wq[$];
  int wc[$];
  logic [7:0] d;
  bit s;

  spi_sfr_sequencer #(.TIMEOUT_CYCLES(TO), .HOLDOFF_CYCLES(HO)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_cr1(cfg_cr1), .cfg_cr2(cfg_cr2), .cfg_br(cfg_br),
    .cfg_update(cfg_update), .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_slave(req_slave), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .sfraddr_w(sfraddr_w), .sfrwe(sfrwe), .spidata_o(spidata_o),
    .sfraddr_r(sfraddr_r), .sfr_data_i(sfr_data));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // peripheral read port: one-cycle registered read of status (3) or data register 2 (5)
  always @(posedge clk) sfr_data <= sfraddr_r == 3'd3 ? status : sfraddr_r == 3'd5 ? dr2 : 8'h00;
  always @(negedge clk) if (sfrwe) begin
    wq.push_back({6'd0, sfraddr_w, spidata_o});
    wc.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sfrwe"}, sfrwe, 0);
    chk({tag, "_sfraddr_w"}, sfraddr_w, 0);
    chk({tag, "_spidata"}, spidata_o, 0);
    chk({tag, "_sfraddr_r"}, sfraddr_r, 3);
  endtask

  task automatic send(input logic [7:0] dd, input bit ss);
    int k = 0;
    while (!req_ready && k < 100) begin @(negedge clk); k++; end
    chk("send_ready", req_ready, 1);
    req_valid = 1; req_data = dd; req_slave = ss;
    @(negedge clk);
    req_valid = 0;
    ecfg = mdirty;
    mdirty = 0;
  endtask

  task automatic wait_rsp(output int k);
    k = 0;
    while (!rsp_valid && k < 300) begin @(negedge clk); k++; end
  endtask

  task automatic take_rsp(input string tag, input logic [7:0] ed, input logic ee);
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
    chk({tag, "_rsp_data"}, rsp_data, ed);
    chk({tag, "_rsp_err"}, rsp_err, ee);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk({tag, "_rsp_done"}, rsp_valid, 0);
    chk({tag, "_idle"}, {busy, req_ready}, 2'b01);
  endtask

  // expected write list: config triple when the model says config is dirty, then the data byte
  task automatic chk_writes(input string tag, input bit cfg, input logic [7:0] dd);
    logic [15:0] e[$];
    if (cfg) begin
      e.push_back({8'h00, cfg_cr1});
      e.push_back({8'h01, cfg_cr2});
      e.push_back({8'h02, cfg_br});
    end
    e.push_back({8'h03, dd});
    chk({tag, "_nwr"}, wq.size(), e.size());
    for (int i = 0; i < e.size() && i < wq.size(); i++) begin
      chk($sformatf("%s_wr%0d", tag, i), wq[i], e[i]);
      chk($sformatf("%s_cyc%0d", tag, i), wc[i] - wc[0], i);
    end
    wq.delete();
    wc.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_n = 1;
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    // first transfer with config write
    cfg_cr1 = 8'h10; cfg_cr2 = 8'h00; cfg_br = 8'h03;
    send(8'hA5, 0);
    repeat (40) @(negedge clk);
    dr2 = 8'h3C; status = 8'h01;
    wait_rsp(n);
    take_rsp("t1", 8'h3C, 0);
    chk_writes("t1", ecfg, 8'hA5);
    chk("t1_cfg_model", ecfg, 1);
    // clean config with stale done level still high
    send(8'h5A, 0);
    repeat (30) @(negedge clk);
    chk("t2_stale", {busy, rsp_valid}, 2'b10);
    status = 0;
    repeat (5) @(negedge clk);
    edr = 8'($urandom); dr2 = edr; status = 8'h01;
    wait_rsp(n);
    take_rsp("t2", edr, 0);
    chk_writes("t2", 0, 8'h5A);
    status = 0;
    // backpressure: response stays put and new requests are held off
    d = 8'($urandom);
    send(d, 0);
    repeat (10) @(negedge clk);
    edr = 8'($urandom); dr2 = edr; status = 8'h01;
    wait_rsp(n);
    status = 0;
    chk_writes("bp", 0, d);
    req_valid = 1; req_data = 8'($urandom);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", i), {rsp_valid, rsp_err, rsp_data, req_ready}, {1'b1, 1'b0, edr, 1'b0});
    end
    req_valid = 0;
    chk("bp_nowr", wq.size(), 0);
    take_rsp("bp", edr, 0);
    // slave mode; cfg_update coincides with the BR write
    cfg_cr1 = 8'($urandom); cfg_cr2 = 8'($urandom); cfg_br = 8'($urandom);
    cfg_update = 1; @(negedge clk); cfg_update = 0; mdirty = 1;
    d = 8'($urandom);
    send(d, 1);
    n = 0;
    while (!(sfrwe && sfraddr_w == 2'd2) && n < 10) begin @(negedge clk); n++; end
    cfg_update = 1; @(negedge clk); cfg_update = 0; mdirty = 1;
    repeat (10) @(negedge clk);
    status = 8'h11;
    repeat (10) @(negedge clk);
    chk("sl_ignore_bit0", rsp_valid, 0);
    status = 0;
    repeat (3) @(negedge clk);
    dr2 = 8'h81; status = 8'h02;
    wait_rsp(n);
    take_rsp("sl", 8'h81, 0);
    chk_writes("sl", 1, d);
    status = 0;
    d = 8'($urandom);
    send(d, 0);
    chk("redirty_model", ecfg, 1);
    repeat (12) @(negedge clk);
    edr = 8'($urandom); dr2 = edr; status = 8'h01;
    wait_rsp(n);
    take_rsp("redirty", edr, 0);
    chk_writes("redirty", ecfg, d);
    status = 0;
    // randomized transfers with exact completion latency
    for (int it = 0; it < 8; it++) begin
      int j;
      logic [7:0] m;
      if ($urandom_range(1) == 1) begin
        cfg_cr1 = 8'($urandom); cfg_cr2 = 8'($urandom); cfg_br = 8'($urandom);
        cfg_update = 1; @(negedge clk); cfg_update = 0; mdirty = 1;
      end
      d = 8'($urandom); s = 1'($urandom_range(1));
      send(d, s);
      j = HO + 1 + 3 * int'(ecfg) + int'($urandom_range(0, 15));
      repeat (j) @(negedge clk);
      m = s ? 8'h02 : 8'h01;
      edr = 8'($urandom); dr2 = edr; status = (8'($urandom) & ~m) | m;
      wait_rsp(n);
      chk($sformatf("rnd%0d_lat", it), n, 4);
      take_rsp($sformatf("rnd%0d", it), edr, 0);
      chk_writes($sformatf("rnd%0d", it), ecfg, d);
      status = 0;
    end
    // reset while waiting for done
    d = 8'($urandom);
    send(d, 0);
    repeat (12) @(negedge clk);
    chk("mrst_busy", busy, 1);
    chk_writes("mrst_pre", ecfg, d);
    rst_n = 0;
    #1;
    chk_reset("mrst");
    @(negedge clk);
    chk("mrst_nowe", sfrwe, 0);
    chk("mrst_nowr", wq.size(), 0);
    rst_n = 1; mdirty = 1;
    d = 8'($urandom);
    send(d, 0);
    repeat (10) @(negedge clk);
    edr = 8'($urandom); dr2 = edr; status = 8'h01;
    wait_rsp(n);
    take_rsp("mrst_post", edr, 0);
    chk_writes("mrst_post", 1, d);
    status = 0;
`ifdef SPI_SEQ_TIMEOUT_EN
    d = 8'($urandom);
    send(d, 0);
    wait_rsp(n);
    chk("to_lat", n, HO + 1 + 3 * int'(ecfg) + TO);
    take_rsp("to", 8'h00, 1);
    chk_writes("to", ecfg, d);
    d = 8'($urandom);
    send(d, 0);
    repeat (8) @(negedge clk);
    edr = 8'($urandom); dr2 = edr; status = 8'h01;
    wait_rsp(n);
    take_rsp("to_next", edr, 0);
    chk_writes("to_next", 0, d);
    status = 0;
`else
    d = 8'($urandom);
    send(d, 0);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy && !rsp_valid) n++;
    end
    chk("hang_busy", n, 300);
    chk_writes("hang", ecfg, d);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end
endmodule
